// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 pixel responder: panel defaults, LT24
// command codes, FSM state types, bus word payload and the step table.
package lt24_pkg;

  localparam int unsigned DEF_WIDTH     = 240;
  localparam int unsigned DEF_HEIGHT    = 320;
  localparam int unsigned DEF_WR_CYCLES = 2;
  localparam int unsigned STEP_W        = 4;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(11);

  typedef enum logic [2:0] {IDLE, SETUP, WR_LO, WR_HI, DONE} state_t;
  typedef enum logic [1:0] {BW_IDLE, BW_LO, BW_HI} bw_state_t;

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } bus_word_t;

  // RS/Data for one step of the CASET / PASET / RAMWR sequence
  function automatic bus_word_t step_word(input logic [STEP_W-1:0] step,
                                          input logic [7:0]        x,
                                          input logic [8:0]        y,
                                          input logic [15:0]       pix);
    logic [15:0] xw;
    logic [15:0] yw;
    bus_word_t   w;
    xw     = 16'(x);
    yw     = 16'(y);
    w.rs   = 1'b1;
    w.data = 16'h0000;
    case (step)
      4'd0:       begin w.rs = 1'b0; w.data = 16'(CMD_CASET); end
      4'd1, 4'd3: w.data = {8'h00, xw[15:8]};
      4'd2, 4'd4: w.data = {8'h00, xw[7:0]};
      4'd5:       begin w.rs = 1'b0; w.data = 16'(CMD_PASET); end
      4'd6, 4'd8: w.data = {8'h00, yw[15:8]};
      4'd7, 4'd9: w.data = {8'h00, yw[7:0]};
      4'd10:      begin w.rs = 1'b0; w.data = 16'(CMD_RAMWR); end
      4'd11:      w.data = pix;
      default:    w.data = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lt24_bus_writer.sv
// Single 8080 bus write: on start, latches RS/Data and drives wr_n low for
// WR_CYCLES cycles then high for WR_CYCLES cycles with RS/Data held.
// Ports: clock, reset (sync, active-high), start, park (return RS high),
//        word (RS/Data to send), wr_n/rs/data (bus), lo_end_c/done_c (phase ends).
module lt24_bus_writer
  import lt24_pkg::*;
#(
  parameter int unsigned WR_CYCLES = DEF_WR_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        park,
  input  bus_word_t   word,
  output logic        wr_n,
  output logic        rs,
  output logic [15:0] data,
  output logic        lo_end_c,
  output logic        done_c
);

  localparam int unsigned CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

  bw_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_n_d, rs_d;
  logic [15:0]      data_d;

  // State and bus registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
      wr_n    <= 1'b1;
      rs      <= 1'b1;
      data    <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_n    <= wr_n_d;
      rs      <= rs_d;
      data    <= data_d;
    end
  end

  assign lo_end_c = (state_q == BW_LO) && (cnt_q == CNT_LAST);
  assign done_c   = (state_q == BW_HI) && (cnt_q == CNT_LAST);

  // Strobe timing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_n_d  = wr_n;
    rs_d    = rs;
    data_d  = data;
    case (state_q)
      BW_IDLE: begin
        if (start) begin
          state_d = BW_LO;
          cnt_d   = '0;
          wr_n_d  = 1'b0;
          rs_d    = word.rs;
          data_d  = word.data;
        end else if (park) begin
          rs_d = 1'b1;
        end
      end
      BW_LO: begin
        if (lo_end_c) begin
          state_d = BW_HI;
          cnt_d   = '0;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BW_HI: begin
        if (done_c) begin
          state_d = BW_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = BW_IDLE;
    endcase
  end

endmodule

// File: rtl/lt24_pixel_responder.sv
// Pixel-write responder: accepts xAddr/yAddr/pixelData through the
// pixelWrite/pixelReady handshake and emits CASET, PASET, RAMWR on the LT24 bus.
// Out-of-range pixels are discarded with a one-cycle pixelDropped pulse.
// Ports: clock, reset (sync, active-high), xAddr, yAddr, pixelData, pixelWrite,
//        pixelReady, pixelDropped, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data.
// Option: LT24_ADDR_CACHE_EN skips the CASET/PASET groups when the column/row
//         matches the last in-range pixel written.
module lt24_pixel_responder
  import lt24_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned HEIGHT    = DEF_HEIGHT,
  parameter int unsigned WR_CYCLES = DEF_WR_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        pixelDropped,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data
);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, next_step_c;
  logic              ready_q, ready_d, armed_q, armed_d, drop_q, drop_d;
  logic              cs_n_q, cs_n_d;
  logic [7:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [15:0]       pix_q, pix_d;
  logic              oor_c, start_c, park_c, lo_end_c, done_c;
  bus_word_t         word_c;

`ifdef LT24_ADDR_CACHE_EN
  logic [7:0] last_x_q, last_x_d;
  logic [8:0] last_y_q, last_y_d;
  logic       cache_valid_q, cache_valid_d, skip_y_q, skip_y_d, in_range_q, in_range_d;
  logic       hit_x_c, hit_y_c;
`endif

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      ready_q <= 1'b0;
      armed_q <= 1'b0;
      drop_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
`ifdef LT24_ADDR_CACHE_EN
      last_x_q      <= '0;
      last_y_q      <= '0;
      cache_valid_q <= 1'b0;
      skip_y_q      <= 1'b0;
      in_range_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ready_q <= ready_d;
      armed_q <= armed_d;
      drop_q  <= drop_d;
      cs_n_q  <= cs_n_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
`ifdef LT24_ADDR_CACHE_EN
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      cache_valid_q <= cache_valid_d;
      skip_y_q      <= skip_y_d;
      in_range_q    <= in_range_d;
`endif
    end
  end

  assign oor_c  = (16'(xAddr) >= 16'(WIDTH)) || (16'(yAddr) >= 16'(HEIGHT));
  assign word_c = step_word(step_q, x_q, y_q, pix_q);

`ifdef LT24_ADDR_CACHE_EN
  assign hit_x_c     = cache_valid_q && (xAddr == last_x_q);
  assign hit_y_c     = cache_valid_q && (yAddr == last_y_q);
  // A cached row jumps from the last CASET parameter straight to RAMWR
  assign next_step_c = (step_q == STEP_W'(4) && skip_y_q) ? STEP_W'(10) : step_q + STEP_W'(1);
`else
  assign next_step_c = step_q + STEP_W'(1);
`endif

  // Acceptance and step sequencing
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ready_d = ready_q;
    armed_d = armed_q;
    drop_d  = 1'b0;
    cs_n_d  = cs_n_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    start_c = 1'b0;
    park_c  = 1'b0;
`ifdef LT24_ADDR_CACHE_EN
    last_x_d      = last_x_q;
    last_y_d      = last_y_q;
    cache_valid_d = cache_valid_q;
    skip_y_d      = skip_y_q;
    in_range_d    = in_range_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        // armed lags pixelReady by a cycle so a late-dropped request is not re-accepted
        armed_d = ready_q;
        if (pixelWrite && ready_q && armed_q) begin
          x_d     = xAddr;
          y_d     = yAddr;
          pix_d   = pixelData;
          ready_d = 1'b0;
          armed_d = 1'b0;
`ifdef LT24_ADDR_CACHE_EN
          in_range_d = !oor_c;
          skip_y_d   = hit_y_c;
          step_d     = hit_x_c ? (hit_y_c ? STEP_W'(10) : STEP_W'(5)) : STEP_W'(0);
`endif
          if (oor_c) begin
            drop_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cs_n_d  = 1'b0;
        start_c = 1'b1;
        state_d = WR_LO;
      end
      WR_LO: begin
        if (lo_end_c) state_d = WR_HI;
      end
      WR_HI: begin
        if (done_c) begin
          if (step_q == LAST_STEP) begin
            state_d = DONE;
          end else begin
            step_d  = next_step_c;
            state_d = SETUP;
          end
        end
      end
      DONE: begin
        cs_n_d  = 1'b1;
        park_c  = 1'b1;
        step_d  = '0;
        state_d = IDLE;
`ifdef LT24_ADDR_CACHE_EN
        if (in_range_q) begin
          last_x_d      = x_q;
          last_y_d      = y_q;
          cache_valid_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  lt24_bus_writer #(.WR_CYCLES(WR_CYCLES)) u_bus_writer (
    .clock    (clock),
    .reset    (reset),
    .start    (start_c),
    .park     (park_c),
    .word     (word_c),
    .wr_n     (LT24Wr_n),
    .rs       (LT24RS),
    .data     (LT24Data),
    .lo_end_c (lo_end_c),
    .done_c   (done_c)
  );

  assign pixelReady   = ready_q;
  assign pixelDropped = drop_q;
  assign LT24CS_n     = cs_n_q;
  assign LT24Rd_n     = 1'b1;

endmodule

// File: tb/tb_lt24_pixel_responder.sv
// Self-checking bench for lt24_pixel_responder: randomized pixel writes
// compared against a word-list model of the LT24 pixel sequence.
module tb_lt24_pixel_responder;

  localparam int WIDTH = 240;
  localparam int HEIGHT = 320;
  localparam int WRC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, pixelDropped, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
  logic [15:0] LT24Data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [16:0] cap_q[$];
  logic [16:0] exp_q[$];
  int          lo_q[$];
  int          drop_cnt = 0;
  int          cs_err = 0;
  logic        prev_wr = 1'b1;
  int          lo_len = 0;

`ifdef LT24_ADDR_CACHE_EN
  bit m_valid = 0;
  int m_lx = 0, m_ly = 0;
`endif

  lt24_pixel_responder dut (
    .clock(clock), .reset(reset), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .pixelDropped(pixelDropped), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n),
    .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Data(LT24Data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bus monitor: records each word at the falling strobe and each low-pulse width
  always @(negedge clock) begin
    if (!LT24Wr_n && prev_wr) begin
      cap_q.push_back({LT24RS, LT24Data});
      lo_len = 1;
    end else if (!LT24Wr_n) begin
      lo_len++;
    end else if (!prev_wr) begin
      lo_q.push_back(lo_len);
    end
    if (!LT24Wr_n && LT24CS_n) cs_err++;
    if (pixelDropped) drop_cnt++;
    prev_wr = LT24Wr_n;
  end

  task automatic model_reset();
`ifdef LT24_ADDR_CACHE_EN
    m_valid = 0;
`endif
  endtask

  // Expected bus words for one pixel write
  task automatic model_write(input int x, input int y, input int d, output bit dropped, output int nw);
    int b;
    bit sx, sy;
    b = exp_q.size();
    sx = 0;
    sy = 0;
    nw = 0;
    dropped = !(x < WIDTH && y < HEIGHT);
    if (dropped) return;
`ifdef LT24_ADDR_CACHE_EN
    sx = m_valid && (x == m_lx);
    sy = m_valid && (y == m_ly);
    m_valid = 1;
    m_lx = x;
    m_ly = y;
`endif
    if (!sx) begin
      exp_q.push_back({1'b0, 16'h002A});
      for (int k = 0; k < 2; k++) begin
        exp_q.push_back({1'b1, 16'(x / 256)});
        exp_q.push_back({1'b1, 16'(x % 256)});
      end
    end
    if (!sy) begin
      exp_q.push_back({1'b0, 16'h002B});
      for (int k = 0; k < 2; k++) begin
        exp_q.push_back({1'b1, 16'(y / 256)});
        exp_q.push_back({1'b1, 16'(y % 256)});
      end
    end
    exp_q.push_back({1'b0, 16'h002C});
    exp_q.push_back({1'b1, 16'(d)});
    nw = exp_q.size() - b;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pixelWrite = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // mode 0: drop pixelWrite after accept; 1: hold until pixelReady rises;
  // 2: keep pixelWrite high and scramble inputs while busy
  task automatic issue(input int x, input int y, input int d, input int mode, output int lat, output bit to);
    int t0;
    bit got;
    to = 0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (pixelReady) got = 1;
    end
    if (!got) begin to = 1; return; end
    xAddr = 8'(x);
    yAddr = 9'(y);
    pixelData = 16'(d);
    pixelWrite = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (!pixelReady) got = 1;
    end
    if (!got) begin pixelWrite = 1'b0; to = 1; return; end
    t0 = cyc;
    if (mode == 0) pixelWrite = 1'b0;
    if (mode == 2) begin
      xAddr = 8'($urandom);
      yAddr = 9'($urandom);
      pixelData = 16'($urandom);
    end
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (pixelReady) got = 1;
    end
    if (mode == 1) pixelWrite = 1'b0;
    lat = cyc - t0;
    to = !got;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixelWrite = 1'b1;
    repeat (3) @(negedge clock);
    tests += 6;
    if (pixelReady !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", pixelReady); end
    if (LT24Wr_n !== 1'b1) begin fails++; $display("FAIL rst_wr_n got %b exp 1", LT24Wr_n); end
    if (LT24CS_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n got %b exp 1", LT24CS_n); end
    if (LT24Rd_n !== 1'b1) begin fails++; $display("FAIL rst_rd_n got %b exp 1", LT24Rd_n); end
    if (LT24RS !== 1'b1 || LT24Data !== 16'h0) begin
      fails++; $display("FAIL rst_rs_data got %b/%h exp 1/0000", LT24RS, LT24Data);
    end
    if (pixelDropped !== 1'b0) begin fails++; $display("FAIL rst_drop got %b exp 0", pixelDropped); end
    pixelWrite = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    tests += 2;
    if (pixelReady !== 1'b1) begin fails++; $display("FAIL rel_ready got %b exp 1", pixelReady); end
    if (LT24CS_n !== 1'b1 || LT24Wr_n !== 1'b1) begin
      fails++; $display("FAIL rel_bus got cs=%b wr=%b exp 1/1", LT24CS_n, LT24Wr_n);
    end
  endtask

  task automatic test_single();
    int cb, eb, lb, db, nw, lat;
    bit dr, to;
    apply_reset();
    cb = cap_q.size(); eb = exp_q.size(); lb = lo_q.size(); db = drop_cnt;
    model_write(5, 300, 16'hF800, dr, nw);
    issue(5, 300, 16'hF800, 0, lat, to);
    tests++;
    if (to) begin fails++; $display("FAIL single_timeout got timeout exp response"); end
    tests++;
    if (lat !== 62) begin fails++; $display("FAIL single_latency got %0d exp 62", lat); end
    tests++;
    if (cap_q.size() - cb !== 12) begin fails++; $display("FAIL single_count got %0d exp 12", cap_q.size() - cb); end
    for (int k = 0; k < nw; k++) begin
      logic [16:0] g;
      g = (cb + k < cap_q.size()) ? cap_q[cb + k] : 17'bx;
      tests++;
      if (g !== exp_q[eb + k]) begin fails++; $display("FAIL single_word%0d got %h exp %h", k, g, exp_q[eb + k]); end
    end
    for (int k = lb; k < lo_q.size(); k++) begin
      tests++;
      if (lo_q[k] !== WRC) begin fails++; $display("FAIL single_lo_width got %0d exp %0d", lo_q[k], WRC); end
    end
    tests++;
    if (drop_cnt - db !== 0) begin fails++; $display("FAIL single_drop got %0d exp 0", drop_cnt - db); end
  endtask

  task automatic test_handshake();
    int cb, nw, lat;
    bit dr, to;
    cb = cap_q.size();
    model_write(17, 42, 16'h07E0, dr, nw);
    issue(17, 42, 16'h07E0, 1, lat, to);
    repeat (80) @(negedge clock);
    tests += 2;
    if (to || cap_q.size() - cb !== nw) begin
      fails++; $display("FAIL hs_words got %0d exp %0d (timeout=%0d)", cap_q.size() - cb, nw, to);
    end
    if (pixelReady !== 1'b1) begin fails++; $display("FAIL hs_ready got %b exp 1", pixelReady); end
  endtask

  task automatic test_range();
    int xs[5] = '{240, 0, 255, 239, 0};
    int ys[5] = '{10, 320, 511, 319, 0};
    for (int t = 0; t < 5; t++) begin
      int cb, eb, db, nw, lat, el;
      bit dr, to;
      int d;
      d = int'($urandom_range(0, 65535));
      cb = cap_q.size(); eb = exp_q.size(); db = drop_cnt;
      model_write(xs[t], ys[t], d, dr, nw);
      el = dr ? 2 : nw * (1 + 2 * WRC) + 2;
      issue(xs[t], ys[t], d, 0, lat, to);
      tests += 3;
      if (to || lat !== el) begin fails++; $display("FAIL range%0d_latency got %0d exp %0d", t, lat, el); end
      if (drop_cnt - db !== (dr ? 1 : 0)) begin
        fails++; $display("FAIL range%0d_drop got %0d exp %0d", t, drop_cnt - db, dr ? 1 : 0);
      end
      if (cap_q.size() - cb !== nw) begin fails++; $display("FAIL range%0d_count got %0d exp %0d", t, cap_q.size() - cb, nw); end
      for (int k = 0; k < nw; k++) begin
        logic [16:0] g;
        g = (cb + k < cap_q.size()) ? cap_q[cb + k] : 17'bx;
        tests++;
        if (g !== exp_q[eb + k]) begin fails++; $display("FAIL range%0d_word%0d got %h exp %h", t, k, g, exp_q[eb + k]); end
      end
    end
  endtask

  task automatic test_reset_midseq();
    int cb, eb, nw, lat;
    bit dr, to, got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (pixelReady) got = 1;
    end
    cb = cap_q.size();
    xAddr = 8'd100; yAddr = 9'd200; pixelData = 16'h1234; pixelWrite = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (!pixelReady) got = 1;
    end
    pixelWrite = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (cap_q.size() - cb >= 7) got = 1;
    end
    tests++;
    if (!got) begin fails++; $display("FAIL mid_reach_step6 got %0d words exp 7", cap_q.size() - cb); end
    reset = 1'b1;
    @(negedge clock);
    tests += 3;
    if (LT24CS_n !== 1'b1) begin fails++; $display("FAIL mid_cs_n got %b exp 1", LT24CS_n); end
    if (LT24Wr_n !== 1'b1) begin fails++; $display("FAIL mid_wr_n got %b exp 1", LT24Wr_n); end
    if (pixelReady !== 1'b0) begin fails++; $display("FAIL mid_ready got %b exp 0", pixelReady); end
    reset = 1'b0;
    model_reset();
    cb = cap_q.size(); eb = exp_q.size();
    model_write(100, 200, 16'h1234, dr, nw);
    issue(100, 200, 16'h1234, 0, lat, to);
    tests++;
    if (to || cap_q.size() - cb !== 12) begin fails++; $display("FAIL mid_restart_count got %0d exp 12", cap_q.size() - cb); end
    for (int k = 0; k < nw; k++) begin
      logic [16:0] g;
      g = (cb + k < cap_q.size()) ? cap_q[cb + k] : 17'bx;
      tests++;
      if (g !== exp_q[eb + k]) begin fails++; $display("FAIL mid_word%0d got %h exp %h", k, g, exp_q[eb + k]); end
    end
  endtask

  task automatic test_random();
    int px, py;
    px = 0; py = 0;
    for (int t = 0; t < 10; t++) begin
      int x, y, d, cb, eb, db, nw, lat, el;
      bit dr, to;
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 330));
      d = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) x = px;
      if ($urandom_range(0, 3) == 0) y = py;
      px = x; py = y;
      cb = cap_q.size(); eb = exp_q.size(); db = drop_cnt;
      model_write(x, y, d, dr, nw);
      el = dr ? 2 : nw * (1 + 2 * WRC) + 2;
      issue(x, y, d, 0, lat, to);
      tests += 3;
      if (to || lat !== el) begin fails++; $display("FAIL rnd%0d_latency got %0d exp %0d", t, lat, el); end
      if (drop_cnt - db !== (dr ? 1 : 0)) begin fails++; $display("FAIL rnd%0d_drop got %0d exp %0d", t, drop_cnt - db, dr ? 1 : 0); end
      if (cap_q.size() - cb !== nw) begin fails++; $display("FAIL rnd%0d_count got %0d exp %0d", t, cap_q.size() - cb, nw); end
      for (int k = 0; k < nw; k++) begin
        logic [16:0] g;
        g = (cb + k < cap_q.size()) ? cap_q[cb + k] : 17'bx;
        tests++;
        if (g !== exp_q[eb + k]) begin fails++; $display("FAIL rnd%0d_word%0d got %h exp %h", t, k, g, exp_q[eb + k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cb, eb, ntot, lat;
    bit to, anyto;
    cb = cap_q.size(); eb = exp_q.size(); ntot = 0; anyto = 0;
    for (int t = 0; t < 3; t++) begin
      int x, y, d, nw;
      bit dr;
      x = int'($urandom_range(0, WIDTH - 1));
      y = int'($urandom_range(0, HEIGHT - 1));
      d = int'($urandom_range(0, 65535));
      model_write(x, y, d, dr, nw);
      ntot += nw;
      issue(x, y, d, (t == 2) ? 1 : 2, lat, to);
      anyto |= to;
    end
    repeat (4) @(negedge clock);
    tests++;
    if (anyto || cap_q.size() - cb !== ntot) begin fails++; $display("FAIL b2b_count got %0d exp %0d", cap_q.size() - cb, ntot); end
    for (int k = 0; k < ntot; k++) begin
      logic [16:0] g;
      g = (cb + k < cap_q.size()) ? cap_q[cb + k] : 17'bx;
      tests++;
      if (g !== exp_q[eb + k]) begin fails++; $display("FAIL b2b_word%0d got %h exp %h", k, g, exp_q[eb + k]); end
    end
  endtask

`ifdef LT24_ADDR_CACHE_EN
  task automatic test_cache();
    int xs[3] = '{3, 4, 4};
    int en[3] = '{12, 7, 2};
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      int cb, eb, nw, lat;
      bit dr, to;
      cb = cap_q.size(); eb = exp_q.size();
      model_write(xs[t], 7, 16'h00FF + t, dr, nw);
      issue(xs[t], 7, 16'h00FF + t, 0, lat, to);
      tests += 2;
      if (to || cap_q.size() - cb !== en[t]) begin fails++; $display("FAIL cache%0d_count got %0d exp %0d", t, cap_q.size() - cb, en[t]); end
      if (lat !== en[t] * (1 + 2 * WRC) + 2) begin fails++; $display("FAIL cache%0d_latency got %0d exp %0d", t, lat, en[t] * (1 + 2 * WRC) + 2); end
      for (int k = 0; k < nw; k++) begin
        logic [16:0] g;
        g = (cb + k < cap_q.size()) ? cap_q[cb + k] : 17'bx;
        tests++;
        if (g !== exp_q[eb + k]) begin fails++; $display("FAIL cache%0d_word%0d got %h exp %h", t, k, g, exp_q[eb + k]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_handshake();
    test_range();
    test_reset_midseq();
    test_random();
    test_back_to_back();
`ifdef LT24_ADDR_CACHE_EN
    test_cache();
`endif
    tests++;
    if (cs_err !== 0) begin fails++; $display("FAIL cs_during_strobe got %0d exp 0", cs_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
